// File: rtl/bootram_bus_ctrl_pkg.sv
// Shared definitions for the boot RAM bus controller.
//   NBYTES  : number of byte-lane banks behind one 32-bit word
//   state_t : controller sequencing states
package bootram_bus_ctrl_pkg;

   localparam int unsigned NBYTES = 4;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_OREG,
      RESP,
      GAP
   } state_t;

endpackage

// File: rtl/bootram_bus_ctrl.sv
// Boot RAM bus controller: PicoRV32 native-memory slave driving four 2Kx8
// single-port byte-lane banks (bank i holds byte lane i of each word).
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   mem_s_valid       request valid (already address-decoded)
//   mem_s_ready       one-cycle completion pulse
//   mem_s_addr        byte address, bits [ADDR_W+1:2] select the word
//   mem_s_wdata       write data, byte lane i -> bank i
//   mem_s_wstrb       byte enables, all-zero means read
//   mem_s_rdata       read data, valid with ready and held afterwards
//   ram_ce            shared bank clock enable
//   ram_oce           shared bank output-register enable
//   ram_wre           per-bank write enable
//   ram_ad            shared bank word address
//   ram_din           bank write data, bank i on [8i+7:8i]
//   ram_dout          bank read data, bank i on [8i+7:8i]
// Parameters:
//   ADDR_W            word-address width per bank
//   OUT_REG           1 when banks use their output register (one extra read cycle)
module bootram_bus_ctrl
   import bootram_bus_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W  = 11,
   parameter bit          OUT_REG = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_s_valid,
   output logic                  mem_s_ready,
   input  logic [31:0]           mem_s_addr,
   input  logic [31:0]           mem_s_wdata,
   input  logic [NBYTES-1:0]     mem_s_wstrb,
   output logic [31:0]           mem_s_rdata,
   output logic                  ram_ce,
   output logic                  ram_oce,
   output logic [NBYTES-1:0]     ram_wre,
   output logic [ADDR_W-1:0]     ram_ad,
   output logic [31:0]           ram_din,
   input  logic [31:0]           ram_dout
);

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   ad_q;
   logic [31:0]         din_q;
   logic [31:0]         rdata_q;
   logic                accept;
   logic                capture;

   // Address bits outside the word index are aliases by design.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_s_addr[31:ADDR_W+2], mem_s_addr[1:0]};

   assign accept  = (state == IDLE) && mem_s_valid;
   // Bank data is sampled one cycle after the access, or two with the output register.
   assign capture = (state == RD_OREG) || ((state == RD_WAIT) && !OUT_REG);
   assign mem_s_rdata = rdata_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ad_q    <= '0;
         din_q   <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            ad_q  <= mem_s_addr[ADDR_W+1:2];
            din_q <= mem_s_wdata;
         end
         if (capture) begin
            rdata_q <= ram_dout;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      mem_s_ready = 1'b0;
      ram_ce      = 1'b0;
      ram_wre     = '0;
      ram_oce     = ~OUT_REG;
      ram_ad      = ad_q;
      ram_din     = din_q;
      case (state)
         IDLE: begin
            // Bank pins follow the request combinationally so the access
            // happens on the edge that accepts it.
            ram_ce  = mem_s_valid;
            ram_wre = mem_s_wstrb & {NBYTES{mem_s_valid}};
            ram_ad  = mem_s_addr[ADDR_W+1:2];
            ram_din = mem_s_wdata;
            if (mem_s_valid) begin
               state_nxt = (|mem_s_wstrb) ? RESP : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (OUT_REG) begin
               ram_oce   = 1'b1;
               state_nxt = RD_OREG;
            end else begin
               state_nxt = RESP;
            end
         end
         RD_OREG: state_nxt = RESP;
         RESP: begin
            mem_s_ready = 1'b1;
            state_nxt   = GAP;
         end
         // Master may still hold valid for one cycle after ready; skip it.
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bootram_bus_ctrl.sv
// Self-checking bench for bootram_bus_ctrl: one instance without and one with
// the bank output register, each attached to a behavioural byte-lane bank model.
module tb_bootram_bus_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [2];
   logic        valid [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [3:0]  wstrb [2];
   logic        ready [2];
   logic [31:0] rdata [2];
   logic        ce    [2];
   logic        oce   [2];
   logic [3:0]  wre   [2];
   logic [10:0] ad    [2];
   logic [31:0] din   [2];
   logic [31:0] dout  [2];

   bootram_bus_ctrl #(.ADDR_W(11), .OUT_REG(1'b0)) u_dut0 (
      .clk(clk), .reset(rst[0]), .mem_s_valid(valid[0]), .mem_s_ready(ready[0]),
      .mem_s_addr(addr[0]), .mem_s_wdata(wdata[0]), .mem_s_wstrb(wstrb[0]),
      .mem_s_rdata(rdata[0]), .ram_ce(ce[0]), .ram_oce(oce[0]), .ram_wre(wre[0]),
      .ram_ad(ad[0]), .ram_din(din[0]), .ram_dout(dout[0])
   );

   bootram_bus_ctrl #(.ADDR_W(11), .OUT_REG(1'b1)) u_dut1 (
      .clk(clk), .reset(rst[1]), .mem_s_valid(valid[1]), .mem_s_ready(ready[1]),
      .mem_s_addr(addr[1]), .mem_s_wdata(wdata[1]), .mem_s_wstrb(wstrb[1]),
      .mem_s_rdata(rdata[1]), .ram_ce(ce[1]), .ram_oce(oce[1]), .ram_wre(wre[1]),
      .ram_ad(ad[1]), .ram_din(din[1]), .ram_dout(dout[1])
   );

   // Single-port byte banks: bypass read data one cycle after ce, optional output register.
   logic [7:0]  bank [2][4][2048];
   logic [31:0] dq   [2];
   logic [31:0] oq   [2];

   always @(posedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if (ce[l]) begin
            for (int b = 0; b < 4; b++) begin
               if (wre[l][b]) bank[l][b][ad[l]] <= din[l][8*b +: 8];
               else           dq[l][8*b +: 8]   <= bank[l][b][ad[l]];
            end
         end
         if (oce[l]) oq[l] <= dq[l];
      end
   end

   assign dout[0] = dq[0];
   assign dout[1] = oq[1];

   // Expected values for the current cycle, plus the reference word memory.
   logic        e_ready  [2];
   logic        e_ce     [2];
   logic        e_oce    [2];
   logic        e_chk_ad [2];
   logic [3:0]  e_wre    [2];
   logic [10:0] e_ad     [2];
   logic [31:0] e_din    [2];
   logic [31:0] e_rdata  [2];
   logic [31:0] em       [2][2048];

   logic [10:0] pool [8] = '{11'd4, 11'd0, 11'd1, 11'd2, 11'd100, 11'd2047, 11'd1024, 11'd7};

   int checks = 0;
   int errors = 0;

   function automatic logic out_reg(int l);
      return (l == 1);
   endfunction

   task automatic chk(string nm, int l, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lane%0d: got %h want %h at %0t", nm, l, act, exp, $time);
      end
   endtask

   task automatic set_idle(int l);
      e_ready[l]  = 1'b0;
      e_ce[l]     = 1'b0;
      e_wre[l]    = 4'h0;
      e_oce[l]    = ~out_reg(l);
      e_chk_ad[l] = 1'b0;
   endtask

   task automatic compare_all();
      for (int l = 0; l < 2; l++) begin
         chk("ready", l, 32'(ready[l]), 32'(e_ready[l]));
         chk("ce",    l, 32'(ce[l]),    32'(e_ce[l]));
         chk("wre",   l, 32'(wre[l]),   32'(e_wre[l]));
         chk("oce",   l, 32'(oce[l]),   32'(e_oce[l]));
         chk("rdata", l, rdata[l],      e_rdata[l]);
         if (e_chk_ad[l]) begin
            chk("ad",  l, 32'(ad[l]), 32'(e_ad[l]));
            chk("din", l, din[l],     e_din[l]);
         end
      end
   endtask

   task automatic begin_cycle();
      @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) set_idle(l);
   endtask

   task automatic end_cycle();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_cycle();
      begin_cycle();
      valid[0] = 1'b0;
      valid[1] = 1'b0;
      end_cycle();
   endtask

   // One request on lane l; valid held through the cycle after ready unless drop.
   task automatic xact(int l, logic [31:0] a, logic [31:0] d, logic [3:0] s, bit drop,
                       output int lat_seen);
      int lat;
      logic [10:0] w;
      w = a[12:2];
      lat = (s != 4'h0) ? 1 : (out_reg(l) ? 3 : 2);
      lat_seen = -1;
      begin_cycle();
      valid[l] = 1'b1; addr[l] = a; wdata[l] = d; wstrb[l] = s;
      e_ce[l] = 1'b1; e_wre[l] = s; e_chk_ad[l] = 1'b1; e_ad[l] = w; e_din[l] = d;
      end_cycle();
      for (int b = 0; b < 4; b++)
         if (s[b]) em[l][w][8*b +: 8] = d[8*b +: 8];
      for (int i = 1; i <= lat + 1; i++) begin
         begin_cycle();
         if (drop) begin
            valid[l] = 1'b0; addr[l] = $urandom; wdata[l] = $urandom; wstrb[l] = 4'($urandom);
         end
         e_chk_ad[l] = 1'b1; e_ad[l] = w; e_din[l] = d;
         e_ready[l] = (i == lat);
         if (out_reg(l)) e_oce[l] = (s == 4'h0) && (i == 1);
         if (i == lat && s == 4'h0) e_rdata[l] = em[l][w];
         end_cycle();
         if (ready[l] === 1'b1 && lat_seen < 0) lat_seen = i;
      end
   endtask

   // Read interrupted by reset in its wait cycle: no response, rdata cleared.
   task automatic rst_test(int l, logic [31:0] a);
      begin_cycle();
      valid[l] = 1'b1; addr[l] = a; wstrb[l] = 4'h0;
      e_ce[l] = 1'b1; e_chk_ad[l] = 1'b1; e_ad[l] = a[12:2]; e_din[l] = wdata[l];
      end_cycle();
      begin_cycle();
      rst[l] = 1'b1; valid[l] = 1'b0; e_rdata[l] = 32'h0;
      end_cycle();
      begin_cycle();
      end_cycle();
      begin_cycle();
      rst[l] = 1'b0;
      end_cycle();
      repeat (3) begin
         begin_cycle();
         end_cycle();
      end
   endtask

   initial begin
      int ls;
      int rl;
      logic [10:0] w;
      logic [31:0] a;
      logic [3:0]  s;
      for (int l = 0; l < 2; l++) begin
         rst[l] = 1'b1; valid[l] = 1'b0; addr[l] = '0; wdata[l] = '0; wstrb[l] = '0;
         set_idle(l);
         e_rdata[l] = 32'h0;
      end
      repeat (2) begin
         begin_cycle();
         end_cycle();
      end
      for (int l = 0; l < 2; l++) chk("rst_rdata", l, rdata[l], 32'h0);
      begin_cycle();
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      end_cycle();

      for (int l = 0; l < 2; l++) begin
         rl = out_reg(l) ? 3 : 2;
         xact(l, 32'h10, 32'hA1B2C3D4, 4'hF, 1'b0, ls);
         chk("wr_lat", l, 32'(ls), 32'd1);
         xact(l, 32'h10, 32'h55667788, 4'b0010, 1'b0, ls);
         xact(l, 32'h10, 32'h0, 4'h0, 1'b0, ls);
         chk("rd_lat", l, 32'(ls), 32'(rl));
         chk("merge", l, rdata[l], 32'hA1B277D4);
         xact(l, 32'h0, 32'h12345678, 4'hF, 1'b1, ls);
         xact(l, 32'h2000, 32'h0, 4'h0, 1'b0, ls);
         chk("alias", l, rdata[l], 32'h12345678);
         rst_test(l, 32'h10);
         xact(l, 32'h10, 32'h0, 4'h0, 1'b1, ls);
         chk("post_rst", l, rdata[l], 32'hA1B277D4);
         chk("post_rst_lat", l, 32'(ls), 32'(rl));
         for (int p = 0; p < 8; p++)
            xact(l, 32'(pool[p]) << 2, $urandom, 4'hF, 1'b0, ls);
         repeat (120) begin
            w = pool[$urandom_range(0, 7)];
            a = ($urandom & 32'hFFFF_E003) | (32'(w) << 2);
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            xact(l, a, $urandom, s, ($urandom_range(0, 3) == 0), ls);
            repeat ($urandom_range(0, 2)) idle_cycle();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
